// File: rtl/prog_loader.sv
// prog_loader: parses a framed program image from the UART byte stream
// (sync, length, 16-bit words, XOR checksum), writes each word to DRAM from
// BASE_ADDR upward, and holds the CPU in reset until a frame loads cleanly.
module prog_loader #(
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_rst_n,
  output logic [15:0]           words_written
);

  localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_W_H,
    S_W_L,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [15:0]      len;
  logic [7:0]       hi_byte;
  logic [7:0]       chk_acc;
  logic [CNT_W-1:0] idle_cnt;

  logic             timed_c;
  logic             timeout_c;
  logic [15:0]      len_c;
  logic [15:0]      ww_inc_c;

  // Idle supervision applies only to states that are waiting on the UART
  assign timed_c   = (state == S_LEN_H) || (state == S_LEN_L) || (state == S_W_H) ||
                     (state == S_W_L)   || (state == S_CHK);
  assign timeout_c = timed_c && !rx_valid && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign len_c     = {len[15:8], rx_data};
  assign ww_inc_c  = words_written + 16'd1;

  // Idle counter: cleared by any byte and outside the timed states
  always_ff @(posedge clk) begin
    if (!rst_n || rx_valid || !timed_c) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Frame parser, write handshake and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      len           <= '0;
      hi_byte       <= '0;
      chk_acc       <= '0;
      mem_wr_req    <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      cpu_rst_n     <= 1'b0;
      words_written <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state         <= S_LEN_H;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            cpu_rst_n     <= 1'b0;
            words_written <= '0;
            chk_acc       <= '0;
          end
        end
        S_LEN_H: begin
          if (rx_valid) begin
            len[15:8] <= rx_data;
            chk_acc   <= chk_acc ^ rx_data;
            state     <= S_LEN_L;
          end else if (timeout_c) begin
            state <= S_ERR;
          end
        end
        S_LEN_L: begin
          if (rx_valid) begin
            len[7:0] <= rx_data;
            chk_acc  <= chk_acc ^ rx_data;
            if (32'(len_c) > MAX_WORDS) begin
              state <= S_ERR;
            end else if (len_c == 16'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_W_H;
            end
          end else if (timeout_c) begin
            state <= S_ERR;
          end
        end
        S_W_H: begin
          if (rx_valid) begin
            hi_byte <= rx_data;
            chk_acc <= chk_acc ^ rx_data;
            state   <= S_W_L;
          end else if (timeout_c) begin
            state <= S_ERR;
          end
        end
        S_W_L: begin
          if (rx_valid) begin
            chk_acc    <= chk_acc ^ rx_data;
            mem_wr_req <= 1'b1;
            mem_addr   <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(words_written);
            mem_wdata  <= {hi_byte, rx_data};
            state      <= S_WRITE;
          end else if (timeout_c) begin
            state <= S_ERR;
          end
        end
        S_WRITE: begin
          // A byte arriving mid-write is an overrun; it wins over a same-cycle ack
          if (rx_valid) begin
            mem_wr_req <= 1'b0;
            state      <= S_ERR;
          end else if (mem_ack) begin
            mem_wr_req    <= 1'b0;
            words_written <= ww_inc_c;
            state         <= (ww_inc_c == len) ? S_CHK : S_W_H;
          end
        end
        S_CHK: begin
          if (rx_valid) begin
            state <= (rx_data == chk_acc) ? S_DONE : S_ERR;
          end else if (timeout_c) begin
            state <= S_ERR;
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          cpu_rst_n <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized frames for prog_loader, checked
// against a frame-level model (length, checksum, expected writes).
module tb_prog_loader;

  localparam int unsigned BASE = 0;
  localparam int unsigned AW   = 16;
  localparam int unsigned MAXW = 1024;
  localparam int unsigned TMO  = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ack;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_rst_n;
  logic [15:0]   words_written;

  int checks = 0;
  int errors = 0;

  // Memory-side responder controls and write log
  bit            ack_en    = 1'b1;
  bit            force_ack = 1'b0;
  int            ack_delay = 5;
  int            req_cycles = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];

  logic [7:0]    frame_q[$];

  prog_loader #(
    .BASE_ADDR(BASE), .ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .error(error),
    .cpu_rst_n(cpu_rst_n), .words_written(words_written)
  );

  always #10 clk = ~clk;

  // DRAM controller stand-in: acks after ack_delay cycles and logs the write
  initial begin : responder
    int wait_n;
    wait_n  = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_wr_req) req_cycles++;
      if (force_ack) begin
        mem_ack = 1'b1;
      end else if (mem_wr_req && ack_en) begin
        if (wait_n >= ack_delay) begin
          mem_ack = 1'b1;
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_write_done(input string tag);
    int n;
    n = 0;
    while (mem_wr_req && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s.write_ack", tag), 32'(mem_wr_req), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Send bytes [first, last) of frame_q, pausing after each word's LO byte
  task automatic send_frame(input int first, input int last);
    int len;
    len = int'({frame_q[1], frame_q[2]});
    for (int i = first; i < last; i++) begin
      send_byte(frame_q[i]);
      if (ack_en && len <= int'(MAXW) && i >= 4 && i < 3 + 2 * len && ((i - 3) % 2) == 1)
        wait_write_done($sformatf("byte%0d", i));
    end
  endtask

  task automatic append_chk(input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) x ^= frame_q[i];
    if (corrupt) x ^= 8'($urandom_range(255, 1));
    frame_q.push_back(x);
  endtask

  task automatic build_frame(input int len, input bit corrupt);
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(len >> 8));
    frame_q.push_back(8'(len));
    for (int i = 0; i < 2 * len; i++) frame_q.push_back(8'($urandom));
    append_chk(corrupt);
  endtask

  // Frame-level reference: outcome, word count and the expected write log
  task automatic check_result(input string tag);
    logic [15:0] len;
    logic [7:0]  x;
    bit          len_ok;
    bit          exp_done;
    int          n_exp;
    len    = {frame_q[1], frame_q[2]};
    len_ok = (32'(len) <= MAXW);
    n_exp  = len_ok ? int'(len) : 0;
    x      = 8'h00;
    exp_done = 1'b0;
    if (len_ok) begin
      for (int i = 1; i < 3 + 2 * n_exp; i++) x ^= frame_q[i];
      exp_done = (x == frame_q[3 + 2 * n_exp]);
    end
    chk($sformatf("%s.done", tag),      32'(done),          32'(exp_done));
    chk($sformatf("%s.error", tag),     32'(error),         32'(!exp_done));
    chk($sformatf("%s.cpu_rst_n", tag), 32'(cpu_rst_n),     32'(exp_done));
    chk($sformatf("%s.busy", tag),      32'(busy),          32'd0);
    chk($sformatf("%s.words", tag),     32'(words_written), 32'(n_exp));
    chk($sformatf("%s.nwrites", tag),   32'(wr_data_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < wr_data_q.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), 32'(wr_addr_q[i]), (BASE + 32'(i)) % (32'd1 << AW));
      chk($sformatf("%s.data%0d", tag, i), 32'(wr_data_q[i]),
          32'({frame_q[3 + 2 * i], frame_q[4 + 2 * i]}));
    end
  endtask

  task automatic run_frame(input string tag);
    int last;
    wr_addr_q.delete();
    wr_data_q.delete();
    req_cycles = 0;
    last = (32'({frame_q[1], frame_q[2]}) > MAXW) ? 3 : frame_q.size();
    send_frame(0, last);
    wait_idle(64);
    check_result(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk($sformatf("%s.busy", tag),  32'(busy),          32'd0);
    chk($sformatf("%s.req", tag),   32'(mem_wr_req),    32'd0);
    chk($sformatf("%s.addr", tag),  32'(mem_addr),      32'd0);
    chk($sformatf("%s.wdata", tag), 32'(mem_wdata),     32'd0);
    chk($sformatf("%s.done", tag),  32'(done),          32'd0);
    chk($sformatf("%s.error", tag), 32'(error),         32'd0);
    chk($sformatf("%s.cpu", tag),   32'(cpu_rst_n),     32'd0);
    chk($sformatf("%s.words", tag), 32'(words_written), 32'd0);
  endtask

  initial begin : stimulus
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reference program, correct checksum, ack 5 cycles after request
    ack_delay = 5;
    frame_q = '{8'hA5, 8'h00, 8'h03, 8'h40, 8'h41, 8'h00, 8'h09, 8'hE0, 8'h00};
    append_chk(1'b0);
    run_frame("good");

    // Same program with checksum 0x00
    frame_q = '{8'hA5, 8'h00, 8'h03, 8'h40, 8'h41, 8'h00, 8'h09, 8'hE0, 8'h00, 8'h00};
    run_frame("badchk");

    // Zero-length frame
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("zero");
    chk("zero.no_req", 32'(req_cycles), 32'd0);

    // Oversized length (1025 words)
    frame_q = '{8'hA5, 8'h04, 8'h01};
    run_frame("toolong");
    chk("toolong.no_req", 32'(req_cycles), 32'd0);

    // Random frames, random ack latency, occasional corrupted checksum
    for (int k = 0; k < 6; k++) begin
      ack_delay = int'($urandom_range(4, 0));
      build_frame(int'($urandom_range(8, 1)), ($urandom_range(3, 0) == 0));
      run_frame($sformatf("rand%0d", k));
    end

    // Garbage ahead of the sync byte is ignored
    ack_delay = 1;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    chk("garbage.busy", 32'(busy), 32'd0);
    build_frame(3, 1'b0);
    run_frame("after_garbage");

    // Reload after a good load: CPU hold reasserts on the sync edge
    build_frame(2, 1'b0);
    wr_addr_q.delete();
    wr_data_q.delete();
    chk("reload.done_before", 32'(done), 32'd1);
    send_byte(frame_q[0]);
    chk("reload.cpu_on_sync",  32'(cpu_rst_n),     32'd0);
    chk("reload.done_on_sync", 32'(done),          32'd0);
    chk("reload.busy_on_sync", 32'(busy),          32'd1);
    chk("reload.words_clear",  32'(words_written), 32'd0);
    send_frame(1, frame_q.size());
    wait_idle(64);
    check_result("reload");

    // Overrun: byte arrives while the write is still unacknowledged
    build_frame(2, 1'b0);
    ack_en = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_frame(0, 5);
    chk("ovr.req_up", 32'(mem_wr_req), 32'd1);
    chk("ovr.addr",   32'(mem_addr),   BASE % (32'd1 << AW));
    chk("ovr.wdata",  32'(mem_wdata),  32'({frame_q[3], frame_q[4]}));
    repeat (2) @(negedge clk);
    send_byte(8'h77);
    chk("ovr.req_drop", 32'(mem_wr_req), 32'd0);
    @(negedge clk);
    chk("ovr.error", 32'(error), 32'd1);
    chk("ovr.busy",  32'(busy),  32'd0);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("ovr.late_ack_words", 32'(words_written),    32'd0);
    chk("ovr.late_ack_log",   32'(wr_data_q.size()), 32'd0);
    chk("ovr.error_held",     32'(error),            32'd1);
    chk("ovr.cpu_held",       32'(cpu_rst_n),        32'd0);
    ack_en = 1'b1;

    // Mid-frame silence trips the idle timeout
    build_frame(5, 1'b0);
    send_frame(0, 3);
    repeat (TMO / 2) @(negedge clk);
    chk("tmo.not_yet", 32'(error), 32'd0);
    chk("tmo.busy",    32'(busy),  32'd1);
    wait_idle(int'(TMO) * 2);
    chk("tmo.error", 32'(error),     32'd1);
    chk("tmo.done",  32'(done),      32'd0);
    chk("tmo.cpu",   32'(cpu_rst_n), 32'd0);
    chk("tmo.idle",  32'(busy),      32'd0);

    // Reset pulse in the middle of a write
    build_frame(1, 1'b0);
    ack_en = 1'b0;
    wr_data_q.delete();
    send_frame(0, 5);
    chk("rstw.req_up", 32'(mem_wr_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("rstw");
    rst_n  = 1'b1;
    ack_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstw.no_write", 32'(wr_data_q.size()), 32'd0);

    // Fresh load after the reset
    ack_delay = int'($urandom_range(3, 0));
    build_frame(4, 1'b0);
    run_frame("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
